sc_statemachine_player: RTL and testbench

//   Sequencer for the player-position shift register (one-hot, DATAWIDTH bits).

---
 rtl/sc_statemachine_player_if.sv | 37 +++
 rtl/sc_statemachine_player.sv | 124 ++++++++++++
 tb/tb_sc_statemachine_player.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sc_statemachine_player_if.sv
// -----------------------------------------------------------------------------
// sc_statemachine_player_if
// Purpose : Groups the player sequencer's button, bus and command signals.
//           The master side is the board environment (debounced buttons,
//           player register, obstacle row); the slave side is the sequencer.
// Signals :
//   left_InLow            left button, debounced, active-low
//   right_InLow           right button, debounced, active-low
//   start_InLow           start/restart button, debounced, active-low
//   position_InBUS        current player register contents (one-hot)
//   obstacle_InBUS        obstacle row at the player's row
//   clear_OutLow          player register clear (0 = load init position)
//   shiftselection_OutBUS 01 = shift toward MSB, 10 = shift toward LSB, 00 = hold
//   gameover_OutHigh      1 while the game is lost
// -----------------------------------------------------------------------------
interface sc_statemachine_player_if #(
   parameter int DATAWIDTH = 8
);
   logic                 left_InLow;
   logic                 right_InLow;
   logic                 start_InLow;
   logic [DATAWIDTH-1:0] position_InBUS;
   logic [DATAWIDTH-1:0] obstacle_InBUS;
   logic                 clear_OutLow;
   logic [1:0]           shiftselection_OutBUS;
   logic                 gameover_OutHigh;

   modport master (
      output left_InLow, right_InLow, start_InLow, position_InBUS, obstacle_InBUS,
      input  clear_OutLow, shiftselection_OutBUS, gameover_OutHigh
   );

   modport slave (
      input  left_InLow, right_InLow, start_InLow, position_InBUS, obstacle_InBUS,
      output clear_OutLow, shiftselection_OutBUS, gameover_OutHigh
   );
endinterface

// File: rtl/sc_statemachine_player.sv
// -----------------------------------------------------------------------------
// sc_statemachine_player
// Purpose : Sequencer for the one-hot player-position shift register. Turns the
//           left/right buttons into single-cycle shift commands with
//           auto-repeat, blocks moves at the edges (no wrap-around) and
//           detects collision with the obstacle row.
// Ports   :
//   SC_STATEMACHINE_PLAYER_CLOCK_50    system clock, rising edge
//   SC_STATEMACHINE_PLAYER_RESET_InLow synchronous reset, active-low
//   SC_STATEMACHINE_PLAYER_bus         slave side of sc_statemachine_player_if
//                                      (buttons, position/obstacle in;
//                                       clear/shiftselection/gameover out)
// Outputs are Moore, decoded from the state register only.
// -----------------------------------------------------------------------------
module sc_statemachine_player #(
   parameter int DATAWIDTH    = 8,
   parameter int REPEAT_TICKS = 12500000
) (
   input  logic                    SC_STATEMACHINE_PLAYER_CLOCK_50,
   input  logic                    SC_STATEMACHINE_PLAYER_RESET_InLow,
   sc_statemachine_player_if.slave SC_STATEMACHINE_PLAYER_bus
);

   localparam int               CNT_W    = (REPEAT_TICKS > 1) ? $clog2(REPEAT_TICKS) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REPEAT_TICKS - 1);

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_SHIFT_L = 3'd2,
      ST_SHIFT_R = 3'd3,
      ST_HOLD    = 3'd4,
      ST_LOST    = 3'd5
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] hold_cnt_q;
   logic             collision;
   logic             left_ok;
   logic             right_ok;

   assign collision = |(SC_STATEMACHINE_PLAYER_bus.position_InBUS &
                        SC_STATEMACHINE_PLAYER_bus.obstacle_InBUS);

   // Exactly one button pressed and the player not already at that edge.
   assign left_ok  = !SC_STATEMACHINE_PLAYER_bus.left_InLow &&
                      SC_STATEMACHINE_PLAYER_bus.right_InLow &&
                     !SC_STATEMACHINE_PLAYER_bus.position_InBUS[DATAWIDTH-1];
   assign right_ok = !SC_STATEMACHINE_PLAYER_bus.right_InLow &&
                      SC_STATEMACHINE_PLAYER_bus.left_InLow &&
                     !SC_STATEMACHINE_PLAYER_bus.position_InBUS[0];

   // NOTE: the reset is sampled inside the clocked block (synchronous), and all
   // state is updated with non-blocking assignments so every register sees the
   // pre-edge values of the others.
   always_ff @(posedge SC_STATEMACHINE_PLAYER_CLOCK_50) begin
      if (!SC_STATEMACHINE_PLAYER_RESET_InLow) begin
         state_q    <= ST_INIT;
         hold_cnt_q <= '0;
      end else begin
         state_q <= state_d;
         // Counter is 0 in the first HOLD cycle and counts up while in HOLD.
         if (state_q == ST_HOLD) begin
            hold_cnt_q <= hold_cnt_q + CNT_W'(1);
         end else begin
            hold_cnt_q <= '0;
         end
      end
   end

   // NOTE: state_d gets its default before the case so every path assigns it
   // and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: state_d = ST_IDLE;
         ST_IDLE: begin
            if (collision) begin
               state_d = ST_LOST;
            end else if (left_ok) begin
               state_d = ST_SHIFT_L;
            end else if (right_ok) begin
               state_d = ST_SHIFT_R;
            end
         end
         // Collision is not checked here: the player register is mid-update.
         ST_SHIFT_L: state_d = ST_HOLD;
         ST_SHIFT_R: state_d = ST_HOLD;
         ST_HOLD: begin
            if (collision) begin
               state_d = ST_LOST;
            end else if (SC_STATEMACHINE_PLAYER_bus.left_InLow &&
                         SC_STATEMACHINE_PLAYER_bus.right_InLow) begin
               state_d = ST_IDLE;
            end else if (hold_cnt_q == CNT_LAST) begin
               // Back to IDLE, which re-evaluates: a held button repeats.
               state_d = ST_IDLE;
            end
         end
         ST_LOST: begin
            if (!SC_STATEMACHINE_PLAYER_bus.start_InLow) begin
               state_d = ST_INIT;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Moore output decode.
   always_comb begin
      SC_STATEMACHINE_PLAYER_bus.clear_OutLow          = 1'b1;
      SC_STATEMACHINE_PLAYER_bus.shiftselection_OutBUS = 2'b00;
      SC_STATEMACHINE_PLAYER_bus.gameover_OutHigh      = 1'b0;
      case (state_q)
         ST_INIT:    SC_STATEMACHINE_PLAYER_bus.clear_OutLow          = 1'b0;
         ST_SHIFT_L: SC_STATEMACHINE_PLAYER_bus.shiftselection_OutBUS = 2'b01;
         ST_SHIFT_R: SC_STATEMACHINE_PLAYER_bus.shiftselection_OutBUS = 2'b10;
         ST_LOST:    SC_STATEMACHINE_PLAYER_bus.gameover_OutHigh      = 1'b1;
         default:    ;
      endcase
   end

endmodule

// File: tb/tb_sc_statemachine_player.sv
// -----------------------------------------------------------------------------
// tb_sc_statemachine_player
// Purpose : Scoreboard bench for sc_statemachine_player (REPEAT_TICKS = 4).
//           Stimulus pushes expected output events {cycle, outputs}; a monitor
//           flags every cycle in which clear is low, a shift is commanded or
//           gameover changes, and compares it with the head of the queue.
//           A small player-register model drives the position bus from the
//           DUT's own commands. Output nibble = {clear, shiftsel[1:0], gameover}.
// -----------------------------------------------------------------------------
module tb_sc_statemachine_player;

   localparam int             DW       = 8;
   localparam int             RT       = 4;
   localparam logic [DW-1:0]  INIT_POS = 8'h10;

   localparam logic [3:0] O_INIT = 4'b0000;
   localparam logic [3:0] O_SHL  = 4'b1010;
   localparam logic [3:0] O_SHR  = 4'b1100;
   localparam logic [3:0] O_LOST = 4'b1001;

   typedef struct packed {
      int         cyc;
      int         id;
      logic [3:0] outs;
   } exp_t;

   logic          clk;
   logic          rst_n;
   int            cyc = 0;
   int            checks = 0;
   int            errors = 0;
   exp_t          sb_q[$];
   exp_t          e;
   logic [3:0]    outs;
   logic          go_prev = 1'b0;
   logic          done = 1'b0;
   logic          load_en = 1'b0;
   logic [DW-1:0] load_val = '0;

   sc_statemachine_player_if #(.DATAWIDTH(DW)) bus ();

   sc_statemachine_player #(
      .DATAWIDTH   (DW),
      .REPEAT_TICKS(RT)
   ) dut (
      .SC_STATEMACHINE_PLAYER_CLOCK_50   (clk),
      .SC_STATEMACHINE_PLAYER_RESET_InLow(rst_n),
      .SC_STATEMACHINE_PLAYER_bus        (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Player shift register model: load from the bench, clear, or shift.
   always @(posedge clk) begin
      if (load_en) begin
         bus.position_InBUS <= load_val;
      end else if (!bus.clear_OutLow) begin
         bus.position_InBUS <= INIT_POS;
      end else if (bus.shiftselection_OutBUS == 2'b01) begin
         bus.position_InBUS <= bus.position_InBUS << 1;
      end else if (bus.shiftselection_OutBUS == 2'b10) begin
         bus.position_InBUS <= bus.position_InBUS >> 1;
      end
   end

   task automatic check(input string name, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp_v);
      end
   endtask

   // Monitor: the only process that compares and counts.
   always @(negedge clk) begin
      if (done) begin
         check("sb_drain_pending", sb_q.size(), 0);
         $display("CHECKS %0d ERRORS %0d", checks, errors);
         $finish;
      end else if (cyc >= 1) begin
         outs = {bus.clear_OutLow, bus.shiftselection_OutBUS, bus.gameover_OutHigh};
         if (!outs[3] || (outs[2:1] != 2'b00) || (outs[0] != go_prev)) begin
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL sb_unexpected: got outputs %b at cycle %0d, required no event",
                        outs, cyc);
            end else begin
               e = sb_q.pop_front();
               check($sformatf("ev%0d_cycle", e.id), cyc, e.cyc);
               check($sformatf("ev%0d_outputs", e.id), int'(outs), int'(e.outs));
            end
         end
         go_prev = outs[0];
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   task automatic push_ev(input int c, input logic [3:0] o, input int id);
      exp_t x;
      x.cyc  = c;
      x.id   = id;
      x.outs = o;
      sb_q.push_back(x);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called on a negedge; the register loads on the following posedge.
   task automatic load_pos(input logic [DW-1:0] v);
      load_val = v;
      load_en  = 1'b1;
      @(negedge clk);
      load_en  = 1'b0;
   endtask

   initial begin
      rst_n              = 1'b0;
      bus.left_InLow     = 1'b1;
      bus.right_InLow    = 1'b1;
      bus.start_InLow    = 1'b1;
      bus.obstacle_InBUS = '0;

      // 1: reset held for edges 1 and 2 -> INIT outputs; released -> IDLE.
      push_ev(1, O_INIT, 0);
      push_ev(2, O_INIT, 1);
      idle(2);
      rst_n = 1'b1;
      idle(3);

      // 2: single left press from 0x40 -> one SHIFT_L one cycle later.
      load_pos(8'h40);
      push_ev(cyc + 1, O_SHL, 2);
      bus.left_InLow = 1'b0;
      idle(4);
      bus.left_InLow = 1'b1;
      idle(4);

      // 3: edge blocking at 0x80 (left) and 0x01 (right): no events.
      bus.left_InLow = 1'b0;
      idle(20);
      bus.left_InLow = 1'b1;
      idle(3);
      load_pos(8'h01);
      bus.right_InLow = 1'b0;
      idle(20);
      bus.right_InLow = 1'b1;
      idle(3);

      // 4: held right from 0x10: pulses every 1+RT+1 = 6 cycles until 0x01.
      load_pos(8'h10);
      for (int i = 0; i < 4; i++) push_ev(cyc + 1 + 6 * i, O_SHR, 3 + i);
      bus.right_InLow = 1'b0;
      idle(30);
      bus.right_InLow = 1'b1;
      idle(6);

      // 5a: both buttons pressed -> no move.
      load_pos(8'h10);
      bus.left_InLow  = 1'b0;
      bus.right_InLow = 1'b0;
      idle(10);
      bus.left_InLow  = 1'b1;
      bus.right_InLow = 1'b1;
      idle(3);

      // 5b: collision -> LOST next cycle; buttons ignored; start -> INIT.
      push_ev(cyc + 1, O_LOST, 7);
      bus.obstacle_InBUS = 8'h10;
      idle(2);
      bus.left_InLow = 1'b0;
      idle(8);
      bus.left_InLow  = 1'b1;
      bus.right_InLow = 1'b0;
      idle(8);
      bus.right_InLow = 1'b1;
      idle(2);
      push_ev(cyc + 1, O_INIT, 8);
      bus.obstacle_InBUS = '0;
      bus.start_InLow    = 1'b0;
      idle(1);
      bus.start_InLow = 1'b1;
      idle(4);

      // 6a: reset asserted during HOLD -> INIT, no further pulses.
      load_pos(8'h10);
      push_ev(cyc + 1, O_SHL, 9);
      bus.left_InLow = 1'b0;
      idle(2);
      push_ev(cyc + 1, O_INIT, 10);
      rst_n          = 1'b0;
      bus.left_InLow = 1'b1;
      idle(1);
      rst_n = 1'b1;
      idle(6);

      // 6b: reset asserted during SHIFT_L -> INIT, no further pulses.
      load_pos(8'h10);
      push_ev(cyc + 1, O_SHL, 11);
      bus.left_InLow = 1'b0;
      idle(1);
      push_ev(cyc + 1, O_INIT, 12);
      rst_n          = 1'b0;
      bus.left_InLow = 1'b1;
      idle(1);
      rst_n = 1'b1;
      idle(6);

      done = 1'b1;
   end

endmodule
